dsram_like_resp: RTL

Responder end of the data-side SRAM-like interface that the MEM stage consumes (`data_sram_addr_ok` / `data_sram_data_ok` / `data_sram_rdata`). Accepts load/store requests through the address handshake, performs them on an internal word-addressed RAM, and returns exactly one in-order `data_ok` per accepted request after a programmable latency, with stall inputs that shape both handshakes. Used as the data memory in core-level simulation, and as the reference responder for the fetch/MEM handshake tests.

---
 rtl/dsram_like_resp_pkg.sv | 27 ++
 rtl/dsram_like_resp_fifo.sv | 61 ++++++
 rtl/dsram_like_resp.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dsram_like_resp_pkg.sv
// ---- dsram_like_resp_pkg : shared constants and lane-merge helper for the data-side responder (rev 1.0) ----
`default_nettype none

package dsram_like_resp_pkg;

  localparam logic [1:0] DSRAM_SIZE_B = 2'd0;
  localparam logic [1:0] DSRAM_SIZE_H = 2'd1;
  localparam logic [1:0] DSRAM_SIZE_W = 2'd2;

  localparam int WORD_W = 32;

  function automatic logic [WORD_W-1:0] lane_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [3:0]        strb
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsram_like_resp_fifo.sv
// ---- resp_fifo : synchronous response FIFO with push/pop/empty/full (rev 1.0) ----
`default_nettype none

module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
      if (pop)  rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end

endmodule

`default_nettype wire

// File: rtl/dsram_like_resp.sv
// ---- dsram_like_resp : SRAM-like data-side responder with programmable latency (rev 1.0) ----
`default_nettype none

module dsram_like_resp
  import dsram_like_resp_pkg::*;
#(
  parameter int AW      = 14,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        stall_addr,
  input  logic        stall_resp
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] idx;
  logic          hs;
  logic [31:0]   hs_data;
  logic          push;
  logic [31:0]   push_data;
  logic          pop;
  logic [31:0]   head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] out_cnt;

  assign idx     = addr[AW+1:2];
  assign addr_ok = ~stall_addr & (out_cnt < MAX_CNT);
  assign hs      = req & addr_ok;
  // Loads see RAM contents from before this edge; a same-edge store is impossible.
  assign hs_data = wr ? 32'h0 : mem[idx];

  always_ff @(posedge clk) begin
    if (hs && wr) mem[idx] <= lane_merge(mem[idx], wdata, wstrb);
  end

  // Stage 0 is the handshake itself, so LATENCY-1 registered stages follow it.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push      = hs;
      assign push_data = hs_data;
    end else begin : g_pipe
      logic [LATENCY-1:1] vld;
      logic [31:0]        dat [1:LATENCY-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          vld <= '0;
        end else begin
          vld[1] <= hs;
          for (int i = 2; i < LATENCY; i++) vld[i] <= vld[i-1];
        end
      end

      always_ff @(posedge clk) begin
        dat[1] <= hs_data;
        for (int i = 2; i < LATENCY; i++) dat[i] <= dat[i-1];
      end

      assign push      = vld[LATENCY-1];
      assign push_data = dat[LATENCY-1];
    end
  endgenerate

  resp_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign data_ok = ~fifo_empty & ~stall_resp;
  assign pop     = data_ok;
  assign rdata   = data_ok ? head : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt <= '0;
    end else begin
      case ({hs, pop})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(hs && !pop && out_cnt == MAX_CNT));
      assert (!(pop && !hs && out_cnt == '0));
    end
  end

  // size is informational; full-word reduction keeps the unused address bits visible.
  logic unused_ok;
  assign unused_ok = ^{size, addr, fifo_full};

endmodule

`default_nettype wire
